// File: rtl/serial_negate_scheduler.sv
// Round-robin share of one LSB-first serial negator among NREQ requesters; gnt in cycle 0, result in cycle WIDTH+2.
// One word in flight; DONE holds out_* until out_ready, and req is only sampled in IDLE.
module serial_negate_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  ser_clr,
    output logic                  ser_x,
    input  logic                  ser_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    output logic                  out_ovf
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   pick;
    logic             pick_vld;
    logic [WIDTH-1:0] pick_word;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int o = 0; o < NREQ; o++) begin
            if (!pick_vld && req[(int'(rr_ptr) + o) % NREQ]) begin
                pick_vld = 1'b1;
                pick     = IDW'((int'(rr_ptr) + o) % NREQ);
            end
        end
    end

    assign pick_word = req_data[pick*WIDTH +: WIDTH];

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = LOAD;
                    gnt       = NREQ'(1) << pick;
                end
            end
            LOAD:  state_nxt = SHIFT;
            SHIFT: if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // sr carries the operand out of bit 0 while result bits enter at the MSB.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            sr       <= '0;
            cnt      <= '0;
            ser_clr  <= 1'b1;
            ser_x    <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ser_clr <= (state_nxt == IDLE) || (state_nxt == LOAD);
            ser_x   <= (state_nxt == SHIFT) ? sr[0] : 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        sr      <= pick_word;
                        out_id  <= pick;
                        out_ovf <= (pick_word == {1'b1, {(WIDTH-1){1'b0}}});
                        cnt     <= '0;
                    end
                end
                LOAD: begin
                    rr_ptr <= IDW'((int'(out_id) + 1) % NREQ);
                    sr     <= {1'b0, sr[WIDTH-1:1]};
                end
                SHIFT: begin
                    sr <= {ser_z, sr[WIDTH-1:1]};
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt      <= '0;
                        out_data <= {ser_z, sr[WIDTH-1:1]};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_negate_scheduler.sv
// Bench for serial_negate_scheduler with a behavioural Mealy two's-complementer on the serial port.
module tb_serial_negate_scheduler;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           areset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           busy, ser_clr, ser_x, ser_z, out_valid, out_ovf;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;

    int checks = 0;
    int errors = 0;
    int model_rr = 0;

    always #5 clk = ~clk;

    serial_negate_scheduler #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .areset_n(areset_n), .req(req), .req_data(req_data), .gnt(gnt),
        .busy(busy), .ser_clr(ser_clr), .ser_x(ser_x), .ser_z(ser_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_ovf(out_ovf)
    );

    // Serial negator: copy bits up to and including the first 1, invert the rest.
    logic seen;
    always_ff @(posedge clk or posedge ser_clr) begin
        if (ser_clr) seen <= 1'b0;
        else if (ser_x) seen <= 1'b1;
    end
    assign ser_z = ser_x ^ seen;

    function automatic logic [W-1:0] neg_ref(input logic [W-1:0] d);
        return W'(((1 << W) - int'(d)) % (1 << W));
    endfunction

    function automatic int arb_ref(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
        return -1;
    endfunction

    task automatic set_word(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic test_reset;
        areset_n = 1'b0; req = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 areset_n = 1'b1;
        model_rr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, gnt, ser_clr, out_valid, out_data} !== {1'b0, 4'b0, 1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_idle c%0d: busy=%b gnt=%b clr=%b vld=%b data=%h, want 0 0000 1 0 00",
                         c, busy, gnt, ser_clr, out_valid, out_data);
            end
        end
    endtask

    task automatic test_negate;
        logic [W-1:0] tbl [4] = '{8'h05, 8'h00, 8'h80, 8'hFF};
        int ids [4] = '{1, 3, 0, 2};
        logic [N-1:0] eg;
        int n;
        logic got;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            set_word(ids[t], tbl[t]);
            req[ids[t]] = 1'b1;
            @(negedge clk);
            eg = N'(1) << ids[t];
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL negate_gnt: gnt=%b want %b", gnt, eg); end
            model_rr = (ids[t] + 1) % N;
            got = 1'b0; n = 0;
            for (int c = 1; c <= 40 && !got; c++) begin
                @(posedge clk); #1 req = '0;
                @(negedge clk);
                if (out_valid) begin got = 1'b1; n = c; end
            end
            checks++;
            if (n != W + 2) begin errors++; $display("FAIL negate_latency: %0d cycles want %0d", n, W + 2); end
            checks++;
            if ({out_data, out_id, out_ovf} !== {neg_ref(tbl[t]), 2'(ids[t]), tbl[t] == 8'h80}) begin
                errors++;
                $display("FAIL negate_result op=%h: data=%h id=%0d ovf=%b want %h %0d %b", tbl[t],
                         out_data, out_id, out_ovf, neg_ref(tbl[t]), ids[t], tbl[t] == 8'h80);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL negate_drop: out_valid=%b want 0", out_valid); end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] d [N];
        logic [W-1:0] exp_d [$];
        int exp_i [$];
        int cyc, last, ngr, ei;
        logic [N-1:0] eg;
        areset_n = 1'b0;
        @(posedge clk); #1 areset_n = 1'b1;
        model_rr = 0;
        for (int i = 0; i < N; i++) begin d[i] = W'($urandom); set_word(i, d[i]); end
        req = '1; out_ready = 1'b1;
        cyc = 0; last = -1; ngr = 0;
        while ((ngr < 5 || exp_i.size() != 0) && cyc < 120) begin
            @(negedge clk); cyc++;
            if (gnt != '0) begin
                ei = model_rr;
                eg = N'(1) << ei;
                checks++;
                if (gnt !== eg) begin errors++; $display("FAIL b2b_order: gnt=%b want %b", gnt, eg); end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != W + 3) begin
                        errors++; $display("FAIL b2b_spacing: %0d cycles want %0d", cyc - last, W + 3);
                    end
                end
                last = cyc; ngr++;
                exp_d.push_back(neg_ref(d[ei])); exp_i.push_back(ei);
                model_rr = (ei + 1) % N;
                if (ngr == 5) begin @(posedge clk); #1 req = '0; end
            end
            if (out_valid) begin
                checks++;
                if (exp_i.size() == 0) begin
                    errors++; $display("FAIL b2b_result: unexpected result data=%h want none", out_data);
                end else begin
                    if (out_data !== exp_d[0] || out_id !== 2'(exp_i[0])) begin
                        errors++;
                        $display("FAIL b2b_result: data=%h id=%0d want %h %0d", out_data, out_id, exp_d[0], exp_i[0]);
                    end
                    void'(exp_d.pop_front()); void'(exp_i.pop_front());
                end
            end
        end
        checks++;
        if (ngr != 5 || exp_i.size() != 0) begin
            errors++; $display("FAIL b2b_count: grants=%0d pending=%0d want 5 0", ngr, exp_i.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [W-1:0] d, dj;
        logic got;
        d = W'($urandom) | 8'h01; dj = W'($urandom);
        out_ready = 1'b0;
        @(posedge clk); #1;
        set_word(1, d); set_word(3, dj);
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_gnt: gnt=%b want 0010", gnt); end
        model_rr = 2;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1 req = 4'b1000;
            @(negedge clk);
            got = out_valid;
        end
        for (int s = 0; s < 6; s++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== neg_ref(d) || gnt !== '0) begin
                errors++;
                $display("FAIL bp_hold s%0d: vld=%b data=%h gnt=%b want 1 %h 0000", s, out_valid, out_data, gnt, neg_ref(d));
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_accept_cycle: out_valid=%b want 1", out_valid); end
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || gnt !== 4'b1000) begin
            errors++; $display("FAIL bp_regrant: vld=%b gnt=%b want 0 1000", out_valid, gnt);
        end
        model_rr = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1 req = '0;
            @(negedge clk);
            got = out_valid;
        end
        checks++;
        if (!got || out_data !== neg_ref(dj) || out_id !== 2'd3) begin
            errors++; $display("FAIL bp_second: vld=%b data=%h id=%0d want 1 %h 3", got, out_data, out_id, neg_ref(dj));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] d2, d3;
        logic got;
        d2 = W'($urandom) | 8'h01;
        out_ready = 1'b1;
        set_word(2, d2);
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_gnt: gnt=%b want 0100", gnt); end
        @(posedge clk); #1 req = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ser_clr !== 1'b0) begin
            errors++; $display("FAIL rmid_shift: busy=%b clr=%b want 1 0", busy, ser_clr);
        end
        areset_n = 1'b0;
        #1;
        checks++;
        if ({busy, gnt, ser_clr, ser_x, out_valid, out_data, out_id, out_ovf} !==
            {1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_reset: busy=%b gnt=%b clr=%b x=%b vld=%b data=%h id=%0d ovf=%b want 0 0000 1 0 0 00 0 0",
                     busy, gnt, ser_clr, ser_x, out_valid, out_data, out_id, out_ovf);
        end
        @(posedge clk); #1 areset_n = 1'b1;
        model_rr = 0;
        d2 = W'($urandom); d3 = W'($urandom);
        set_word(2, d2); set_word(3, d3);
        req = 4'b1100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_first_gnt: gnt=%b want 0100", gnt); end
        model_rr = 3;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1 req = '0;
            @(negedge clk);
            got = out_valid;
        end
        checks++;
        if (!got || out_data !== neg_ref(d2) || out_id !== 2'd2) begin
            errors++; $display("FAIL rmid_result: vld=%b data=%h id=%0d want 1 %h 2", got, out_data, out_id, neg_ref(d2));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [N-1:0] mask, eg;
        logic [W-1:0] d [N];
        int ei, stall;
        logic got;
        for (int t = 0; t < 30; t++) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                d[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
                set_word(i, d[i]);
            end
            req = mask; out_ready = 1'b0;
            @(negedge clk);
            ei = arb_ref(mask, model_rr);
            eg = N'(1) << ei;
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL rand_gnt t%0d: gnt=%b want %b", t, gnt, eg); end
            model_rr = (ei + 1) % N;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(posedge clk); #1 req = '0;
                @(negedge clk);
                got = out_valid;
            end
            stall = $urandom_range(0, 3);
            repeat (stall) begin @(posedge clk); #1; @(negedge clk); end
            checks++;
            if (!got || out_valid !== 1'b1 || {out_data, out_id, out_ovf} !== {neg_ref(d[ei]), 2'(ei), d[ei] == 8'h80}) begin
                errors++;
                $display("FAIL rand_result t%0d: vld=%b data=%h id=%0d ovf=%b want 1 %h %0d %b", t, out_valid,
                         out_data, out_id, out_ovf, neg_ref(d[ei]), ei, d[ei] == 8'h80);
            end
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_negate();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
